// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer and the instruction decoder.
package pc_seq_pkg;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_LOAD = 3'd2;
  localparam logic [2:0] CMD_PUSH = 3'd3;
  localparam logic [2:0] CMD_ADDR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INC    = 3'd1,
    ST_CARRY  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_ADDR   = 3'd4,
    ST_PUSH_H = 3'd5,
    ST_PUSH_L = 3'd6
  } pc_state_e;

  // First state of a command; NOP and reserved codes stay in IDLE.
  function automatic pc_state_e cmd_to_state(input logic [2:0] cmd);
    case (cmd)
      CMD_INC:  return ST_INC;
      CMD_LOAD: return ST_LOAD;
      CMD_PUSH: return ST_PUSH_H;
      CMD_ADDR: return ST_ADDR;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_strobes.sv
// Moore decode of sequencer state into the eight PC register strobes.
module pc_seq_strobes
  import pc_seq_pkg::*;
(
  input  pc_state_e state_i,
  output logic      pcl_adlwa_o,
  output logic      pcl_inc_o,
  output logic      pcl_adloa_o,
  output logic      pcl_dboa_o,
  output logic      pch_adhwa_o,
  output logic      pch_inc_o,
  output logic      pch_adhoa_o,
  output logic      pch_dboa_o
);

  // One state drives at most one strobe per register; IDLE drives none.
  always_comb begin
    pcl_adlwa_o = 1'b0;
    pcl_inc_o   = 1'b0;
    pcl_adloa_o = 1'b0;
    pcl_dboa_o  = 1'b0;
    pch_adhwa_o = 1'b0;
    pch_inc_o   = 1'b0;
    pch_adhoa_o = 1'b0;
    pch_dboa_o  = 1'b0;
    case (state_i)
      ST_INC:    pcl_inc_o = 1'b1;
      ST_CARRY:  pch_inc_o = 1'b1;
      ST_LOAD: begin
        pcl_adlwa_o = 1'b1;
        pch_adhwa_o = 1'b1;
      end
      ST_ADDR: begin
        pcl_adloa_o = 1'b1;
        pch_adhoa_o = 1'b1;
      end
      ST_PUSH_H: pch_dboa_o = 1'b1;
      ST_PUSH_L: pcl_dboa_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter command sequencer: accepts one command at a time from IDLE,
// steps through its micro-states and pulses done on the first IDLE cycle after.
//
// state   | meaning
// IDLE    | waiting for a command, busy=0
// INC     | PC-low increments; pclc decides whether PC-high follows
// CARRY   | PC-high increments
// LOAD    | both halves load from ADL/ADH
// ADDR    | both halves drive ADL/ADH
// PUSH_H  | PC-high drives DB
// PUSH_L  | PC-low drives DB
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic       pclc,
  output logic       busy,
  output logic       done,
  output logic       pcl_adlwa,
  output logic       pcl_inc,
  output logic       pcl_adloa,
  output logic       pcl_dboa,
  output logic       pch_adhwa,
  output logic       pch_inc,
  output logic       pch_adhoa,
  output logic       pch_dboa
);

  pc_state_e state_q;
  logic      done_q;

  // State register and done pulse; done is set on the edge leaving a final state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) state_q <= cmd_to_state(cmd);
        end
        ST_INC: begin
          if (pclc) begin
            state_q <= ST_CARRY;
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_PUSH_H: state_q <= ST_PUSH_L;
        ST_CARRY, ST_LOAD, ST_ADDR, ST_PUSH_L: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  pc_seq_strobes u_strobes (
    .state_i     (state_q),
    .pcl_adlwa_o (pcl_adlwa),
    .pcl_inc_o   (pcl_inc),
    .pcl_adloa_o (pcl_adloa),
    .pcl_dboa_o  (pcl_dboa),
    .pch_adhwa_o (pch_adhwa),
    .pch_inc_o   (pch_inc),
    .pch_adhoa_o (pch_adhoa),
    .pch_dboa_o  (pch_dboa)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small PC datapath model driven by the strobes.
module tb_pc_sequencer;

  // {busy, done, pcl_adlwa, pcl_inc, pcl_adloa, pcl_dboa, pch_adhwa, pch_inc, pch_adhoa, pch_dboa}
  localparam logic [9:0] V_IDLE   = 10'b00_0000_0000;
  localparam logic [9:0] V_DONE   = 10'b01_0000_0000;
  localparam logic [9:0] V_INC    = 10'b10_0100_0000;
  localparam logic [9:0] V_CARRY  = 10'b10_0000_0100;
  localparam logic [9:0] V_LOAD   = 10'b10_1000_1000;
  localparam logic [9:0] V_ADDR   = 10'b10_0010_0010;
  localparam logic [9:0] V_PUSH_H = 10'b10_0000_0001;
  localparam logic [9:0] V_PUSH_L = 10'b10_0001_0000;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       pclc;
  logic       busy, done;
  logic       pcl_adlwa, pcl_inc, pcl_adloa, pcl_dboa;
  logic       pch_adhwa, pch_inc, pch_adhoa, pch_dboa;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  logic [7:0] pc_lo, pc_hi;
  logic [7:0] adl_drv, adh_drv;
  logic [7:0] adl_bus, adh_bus, db_bus;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .pclc      (pclc),
    .busy      (busy),
    .done      (done),
    .pcl_adlwa (pcl_adlwa),
    .pcl_inc   (pcl_inc),
    .pcl_adloa (pcl_adloa),
    .pcl_dboa  (pcl_dboa),
    .pch_adhwa (pch_adhwa),
    .pch_inc   (pch_inc),
    .pch_adhoa (pch_adhoa),
    .pch_dboa  (pch_dboa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign adl_bus = pcl_adloa ? pc_lo : adl_drv;
  assign adh_bus = pch_adhoa ? pc_hi : adh_drv;
  assign db_bus  = pch_dboa ? pc_hi : (pcl_dboa ? pc_lo : 8'h00);

  // PC register pair that obeys the strobes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_lo <= 8'h00;
      pc_hi <= 8'h00;
    end else begin
      if (pcl_inc)   pc_lo <= pc_lo + 8'h01;
      if (pcl_adlwa) pc_lo <= adl_bus;
      if (pch_inc)   pc_hi <= pc_hi + 8'h01;
      if (pch_adhwa) pc_hi <= adh_bus;
    end
  end

  function automatic logic [9:0] outs();
    return {busy, done, pcl_adlwa, pcl_inc, pcl_adloa, pcl_dboa,
            pch_adhwa, pch_inc, pch_adhoa, pch_dboa};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive inputs for one cycle, then compare the post-edge outputs with the scoreboard head.
  task automatic cyc(input logic v, input logic [2:0] c, input logic p, input string tag);
    logic [9:0] e;
    cmd_valid = v;
    cmd       = c;
    pclc      = p;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed=%h", tag, outs());
    end else begin
      e = exp_q.pop_front();
      check(tag, {6'd0, outs()}, {6'd0, e});
    end
    check({tag, "_dbo_excl"}, {15'd0, pcl_dboa & pch_dboa}, 16'h0000);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; pclc = 1'b0;
    adl_drv = 8'h00; adh_drv = 8'h00;
    #1;
    check("reset_outs", {6'd0, outs()}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // INC without carry
    exp_q.push_back(V_INC);  cyc(1'b1, 3'd1, 1'b0, "inc_acc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "inc_done");
    exp_q.push_back(V_IDLE); cyc(1'b0, 3'd0, 1'b0, "inc_after");
    check("pc_inc", {pc_hi, pc_lo}, 16'h0001);

    // LOAD 00ff then INC with carry; pclc held high in CARRY must be ignored
    adl_drv = 8'hff; adh_drv = 8'h00;
    exp_q.push_back(V_LOAD); cyc(1'b1, 3'd2, 1'b0, "load_ff_acc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "load_ff_done");
    check("pc_load_ff", {pc_hi, pc_lo}, 16'h00ff);
    exp_q.push_back(V_INC);   cyc(1'b1, 3'd1, 1'b0, "incc_acc");
    exp_q.push_back(V_CARRY); cyc(1'b0, 3'd0, 1'b1, "incc_carry");
    exp_q.push_back(V_DONE);  cyc(1'b0, 3'd0, 1'b1, "incc_done");
    exp_q.push_back(V_IDLE);  cyc(1'b0, 3'd0, 1'b0, "incc_after");
    check("pc_carry", {pc_hi, pc_lo}, 16'h0100);

    // LOAD 1234 then ADDR
    adl_drv = 8'h34; adh_drv = 8'h12;
    exp_q.push_back(V_LOAD); cyc(1'b1, 3'd2, 1'b0, "load_acc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "load_done");
    check("pc_load", {pc_hi, pc_lo}, 16'h1234);
    adl_drv = 8'h00; adh_drv = 8'h00;
    exp_q.push_back(V_ADDR); cyc(1'b1, 3'd4, 1'b0, "addr_acc");
    check("addr_adl", {8'd0, adl_bus}, 16'h0034);
    check("addr_adh", {8'd0, adh_bus}, 16'h0012);
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "addr_done");
    check("pc_after_addr", {pc_hi, pc_lo}, 16'h1234);

    // LOAD abcd, PUSH with INC held during the push, accepted in the done cycle
    adl_drv = 8'hcd; adh_drv = 8'hab;
    exp_q.push_back(V_LOAD); cyc(1'b1, 3'd2, 1'b0, "load_abcd_acc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "load_abcd_done");
    adl_drv = 8'h00; adh_drv = 8'h00;
    exp_q.push_back(V_PUSH_H); cyc(1'b1, 3'd3, 1'b0, "push_acc");
    check("push_db_hi", {8'd0, db_bus}, 16'h00ab);
    exp_q.push_back(V_PUSH_L); cyc(1'b1, 3'd1, 1'b1, "push_l_held");
    check("push_db_lo", {8'd0, db_bus}, 16'h00cd);
    exp_q.push_back(V_DONE); cyc(1'b1, 3'd1, 1'b0, "push_done_held");
    exp_q.push_back(V_INC);  cyc(1'b1, 3'd1, 1'b0, "b2b_acc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "b2b_done");
    check("pc_b2b", {pc_hi, pc_lo}, 16'habce);

    // Reserved and NOP codes are ignored
    exp_q.push_back(V_IDLE); cyc(1'b1, 3'd6, 1'b0, "rsvd6");
    exp_q.push_back(V_IDLE); cyc(1'b1, 3'd7, 1'b1, "rsvd7");
    exp_q.push_back(V_IDLE); cyc(1'b1, 3'd0, 1'b0, "nop");
    exp_q.push_back(V_IDLE); cyc(1'b0, 3'd0, 1'b0, "nop_after");

    // Asynchronous reset during PUSH_H
    exp_q.push_back(V_PUSH_H); cyc(1'b1, 3'd3, 1'b0, "rst_push_acc");
    cmd_valid = 1'b0; cmd = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {6'd0, outs()}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(V_IDLE); cyc(1'b0, 3'd0, 1'b0, "post_rst_idle");
    exp_q.push_back(V_INC);  cyc(1'b1, 3'd1, 1'b0, "post_rst_inc");
    exp_q.push_back(V_DONE); cyc(1'b0, 3'd0, 1'b0, "post_rst_done");
    check("pc_post_rst", {pc_hi, pc_lo}, 16'h0001);

    check("scoreboard_drained", exp_q.size(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
